// File: rtl/cdb_arb_pkg.sv
// Shared CDB constants and the broadcast slot payload used by the completion-bus arbiter.
package cdb_arb_pkg;

  localparam int unsigned CDB_WIDTH = 4;
  localparam int unsigned PR_W      = 7;
  localparam int unsigned AR_W      = 5;

  typedef struct packed {
    logic            valid;
    logic [PR_W-1:0] pr_tag;
    logic [AR_W-1:0] ar_tag;
  } cdb_slot_t;

endpackage

// File: rtl/cdb_arb_pick.sv
// Rotating-priority picker: first set request bit at or after i_start, wrapping modulo N.
module cdb_arb_pick #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = 3
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_start,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  logic [IW:0] w_pos;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_found  = 1'b0;
    w_pos    = '0;
    for (int unsigned j = 0; j < N; j++) begin
      w_pos = {1'b0, i_start} + (IW+1)'(j);
      if (w_pos >= (IW+1)'(N)) w_pos = w_pos - (IW+1)'(N);
      if (!o_found && i_req[w_pos[IW-1:0]]) begin
        o_found                  = 1'b1;
        o_onehot[w_pos[IW-1:0]] = 1'b1;
        o_idx                    = w_pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arb.sv
// Completion-bus arbiter: grants up to CDB_WIDTH units per cycle round-robin, registers the CDB bundle.
// Optional synchronous squash input enabled by CDB_ARB_FLUSH_EN.
module cdb_arb
  import cdb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 8
) (
  input  logic                    clock,
  input  logic                    reset,
`ifdef CDB_ARB_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [NUM_REQ-1:0]      fu_valid,
  input  logic [NUM_REQ*PR_W-1:0] fu_pr_tag,
  input  logic [NUM_REQ*AR_W-1:0] fu_ar_tag,
  output logic [NUM_REQ-1:0]      fu_ready,
  output logic [CDB_WIDTH-1:0]    cdb_broadcast,
  output logic [PR_W-1:0]         cdb_pr_tag0,
  output logic [PR_W-1:0]         cdb_pr_tag1,
  output logic [PR_W-1:0]         cdb_pr_tag2,
  output logic [PR_W-1:0]         cdb_pr_tag3,
  output logic [AR_W-1:0]         cdb_ar_tag0,
  output logic [AR_W-1:0]         cdb_ar_tag1,
  output logic [AR_W-1:0]         cdb_ar_tag2,
  output logic [AR_W-1:0]         cdb_ar_tag3
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      w_ptr_nxt;
  logic [IW-1:0]      w_last;
  logic [IW:0]        w_inc;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_clr;
  logic [CDB_WIDTH-1:0] w_found;
  logic [IW-1:0]      w_idx [CDB_WIDTH];
  logic [NUM_REQ-1:0] w_oh  [CDB_WIDTH];
  logic [PR_W-1:0]    w_pr  [NUM_REQ];
  logic [AR_W-1:0]    w_ar  [NUM_REQ];
  cdb_slot_t          w_slot [CDB_WIDTH];
  cdb_slot_t          r_slot [CDB_WIDTH];

`ifdef CDB_ARB_FLUSH_EN
  assign w_clr = ~reset | flush;
`else
  assign w_clr = ~reset;
`endif

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_pr[i] = fu_pr_tag[i*PR_W +: PR_W];
    assign w_ar[i] = fu_ar_tag[i*AR_W +: AR_W];
  end

  // Each stage sees the requests left over by the earlier stages; all start at r_ptr.
  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_stage
    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_pick;
    logic [IW-1:0]      w_pidx;
    logic               w_pfound;
    if (k == 0) begin : g_first
      assign w_req = fu_valid;
    end else begin : g_next
      assign w_req = g_stage[k-1].w_req & ~g_stage[k-1].w_pick;
    end
    cdb_arb_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .i_req    (w_req),
      .i_start  (r_ptr),
      .o_onehot (w_pick),
      .o_idx    (w_pidx),
      .o_found  (w_pfound)
    );
    assign w_oh[k]    = w_pick;
    assign w_idx[k]   = w_pidx;
    assign w_found[k] = w_pfound;
    assign w_slot[k]  = w_pfound ? {1'b1, w_pr[w_pidx], w_ar[w_pidx]} : '0;
  end

  always_comb begin
    w_grant = '0;
    w_last  = r_ptr;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) begin
      w_grant = w_grant | w_oh[k];
      if (w_found[k]) w_last = w_idx[k];
    end
    w_inc = {1'b0, w_last} + (IW+1)'(1);
    if (w_inc >= (IW+1)'(NUM_REQ)) w_inc = '0;
    w_ptr_nxt = w_found[0] ? w_inc[IW-1:0] : r_ptr;
  end

  assign fu_ready = w_clr ? '0 : w_grant;

  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_ptr <= '0;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) r_slot[k] <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      for (int unsigned k = 0; k < CDB_WIDTH; k++) r_slot[k] <= w_slot[k];
    end
  end

  always_comb begin
    cdb_broadcast = '0;
    for (int unsigned k = 0; k < CDB_WIDTH; k++) cdb_broadcast[k] = r_slot[k].valid;
  end

  assign cdb_pr_tag0 = r_slot[0].pr_tag;
  assign cdb_pr_tag1 = r_slot[1].pr_tag;
  assign cdb_pr_tag2 = r_slot[2].pr_tag;
  assign cdb_pr_tag3 = r_slot[3].pr_tag;
  assign cdb_ar_tag0 = r_slot[0].ar_tag;
  assign cdb_ar_tag1 = r_slot[1].ar_tag;
  assign cdb_ar_tag2 = r_slot[2].ar_tag;
  assign cdb_ar_tag3 = r_slot[3].ar_tag;

endmodule

// File: tb/tb_cdb_arb.sv
// Bench for cdb_arb: directed scenarios plus randomized holding requesters against a scan-order model.
// Exercises the squash input when CDB_ARB_FLUSH_EN is defined.
module tb_cdb_arb;
  import cdb_arb_pkg::*;

  localparam int unsigned N = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 fl;
  logic [N-1:0]         fu_valid;
  logic [N*PR_W-1:0]    fu_pr_tag;
  logic [N*AR_W-1:0]    fu_ar_tag;
  logic [N-1:0]         fu_ready;
  logic [CDB_WIDTH-1:0] cdb_broadcast;
  logic [PR_W-1:0]      cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
  logic [AR_W-1:0]      cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;

  always #5 clock = ~clock;

  cdb_arb #(.NUM_REQ(N)) dut (
    .clock         (clock),
    .reset         (reset),
`ifdef CDB_ARB_FLUSH_EN
    .flush         (fl),
`endif
    .fu_valid      (fu_valid),
    .fu_pr_tag     (fu_pr_tag),
    .fu_ar_tag     (fu_ar_tag),
    .fu_ready      (fu_ready),
    .cdb_broadcast (cdb_broadcast),
    .cdb_pr_tag0   (cdb_pr_tag0),
    .cdb_pr_tag1   (cdb_pr_tag1),
    .cdb_pr_tag2   (cdb_pr_tag2),
    .cdb_pr_tag3   (cdb_pr_tag3),
    .cdb_ar_tag0   (cdb_ar_tag0),
    .cdb_ar_tag1   (cdb_ar_tag1),
    .cdb_ar_tag2   (cdb_ar_tag2),
    .cdb_ar_tag3   (cdb_ar_tag3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] v;
  int pr [N];
  int ar [N];
  int waits [N];
  int m_ptr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PR_W+AR_W-1:0] slot_obs(input int k);
    case (k)
      0:       return {cdb_pr_tag0, cdb_ar_tag0};
      1:       return {cdb_pr_tag1, cdb_ar_tag1};
      2:       return {cdb_pr_tag2, cdb_ar_tag2};
      default: return {cdb_pr_tag3, cdb_ar_tag3};
    endcase
  endfunction

  // One clock: drive, predict grants from the scan rule, check ready, then check the broadcast after the edge.
  task automatic cycle(output logic [N-1:0] obs);
    int units[$];
    logic [N-1:0] exp_rdy;
    logic [CDB_WIDTH-1:0] exp_b;
    logic [PR_W+AR_W-1:0] e;
    logic [PR_W+AR_W-1:0] snap [N];
    fu_valid = v;
    for (int i = 0; i < int'(N); i++) begin
      fu_pr_tag[i*PR_W +: PR_W] = PR_W'(pr[i]);
      fu_ar_tag[i*AR_W +: AR_W] = AR_W'(ar[i]);
      snap[i] = {PR_W'(pr[i]), AR_W'(ar[i])};
    end
    #1;
    exp_rdy = '0;
    if (reset && !fl) begin
      for (int j = 0; j < int'(N); j++) begin
        int u;
        u = (m_ptr + j) % int'(N);
        if (v[u] && units.size() < 4) units.push_back(u);
      end
    end
    foreach (units[q]) exp_rdy[units[q]] = 1'b1;
    obs = fu_ready;
    chk("ready", 32'(fu_ready), 32'(exp_rdy));
    @(posedge clock);
    #1;
    if (!reset || fl) m_ptr = 0;
    else if (units.size() > 0) m_ptr = (units[units.size()-1] + 1) % int'(N);
    exp_b = '0;
    for (int k = 0; k < 4; k++) begin
      e = '0;
      if (k < units.size()) begin
        exp_b[k] = 1'b1;
        e = snap[units[k]];
      end
      chk($sformatf("slot%0d_tags", k), 32'(slot_obs(k)), 32'(e));
    end
    chk("broadcast", 32'(cdb_broadcast), 32'(exp_b));
  endtask

  task automatic pulse_reset();
    logic [N-1:0] o;
    reset = 1'b0;
    v = '0;
    cycle(o);
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] o;
    reset = 1'b0;
    fl = 1'b0;
    v = '1;
    for (int i = 0; i < int'(N); i++) begin
      pr[i] = 0; ar[i] = 0; waits[i] = 0;
    end

    // Reset hold with every unit requesting.
    repeat (2) begin
      cycle(o);
      chk("reset_ready", 32'(o), 32'h0);
    end
    reset = 1'b1;
    v = '0;

    // Sparse requests from ptr=0.
    v = 8'b0101_0010;
    pr[1] = 33; ar[1] = 1; pr[4] = 36; ar[4] = 4; pr[6] = 38; ar[6] = 6;
    cycle(o);
    chk("sparse_ready", 32'(o), 32'h52);
    v = '0;
    cycle(o);

    // Saturation from ptr=0.
    pulse_reset();
    v = '1;
    for (int i = 0; i < int'(N); i++) begin
      pr[i] = 64 + i; ar[i] = 16 + i;
    end
    cycle(o); chk("sat_grant0", 32'(o), 32'h0F);
    cycle(o); chk("sat_grant1", 32'(o), 32'hF0);
    cycle(o); chk("sat_grant2", 32'(o), 32'h0F);
    v = '0;
    cycle(o);

    // Wrap-around from ptr=6 (reached by granting unit 5 alone).
    pulse_reset();
    v = 8'h20;
    cycle(o);
    v = 8'b1110_0111;
    cycle(o); chk("wrap_grant0", 32'(o), 32'hC3);
    v = v & ~o;
    cycle(o); chk("wrap_grant1", 32'(o), 32'h24);
    v = '0;

    // Idle keeps ptr; the following request shows where the scan resumes.
    repeat (3) cycle(o);
    v = 8'b0010_1001;
    cycle(o); chk("after_idle", 32'(o), 32'h29);
    v = '0;

`ifdef CDB_ARB_FLUSH_EN
    pulse_reset();
    v = 8'h10;
    cycle(o);
    v = 8'h0C;
    fl = 1'b1;
    cycle(o); chk("flush_ready", 32'(o), 32'h0);
    fl = 1'b0;
    cycle(o); chk("post_flush", 32'(o), 32'h0C);
    chk("post_flush_slot0", 32'(slot_obs(0)), 32'({PR_W'(pr[2]), AR_W'(ar[2])}));
    v = '0;
`endif

    // Randomized holding requesters with occasional reset/flush.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!v[i] && ($urandom % 3) == 0) begin
          v[i] = 1'b1;
          pr[i] = int'($urandom_range(127, 0));
          ar[i] = int'($urandom_range(31, 0));
        end
      end
      reset = (($urandom % 50) != 0);
`ifdef CDB_ARB_FLUSH_EN
      fl = (($urandom % 40) == 0);
`endif
      cycle(o);
      for (int i = 0; i < int'(N); i++) begin
        if (!reset || fl) waits[i] = 0;
        else if (v[i]) waits[i]++;
        if (o[i]) begin
          chk("fairness", 32'(waits[i] <= 2), 32'h1);
          waits[i] = 0;
          v[i] = 1'b0;
        end
      end
      if (!reset) v = '0;
    end
    reset = 1'b1;
    fl = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
